tt_um_urish_dffram: RTL and testbench

TT_UM_URISH_DFFRAM -- requirements
Module: tt_um_urish_dffram

---
 rtl/tt_um_urish_dffram.sv | 58 +++++
 tb/tb_tt_um_urish_dffram.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tt_um_urish_dffram.sv
// 128 x 8 flip-flop RAM with a registered, write-through read port.
// Memory contents survive reset; only the read register is cleared.
module tt_um_urish_dffram (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   localparam int unsigned AW    = 7;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] addr;
   logic          we;
   logic [DW-1:0] uo_d;
   logic [DW-1:0] uo_q;

   // Decode the packed ui_in bus into address and write enable.
   assign addr = ui_in[AW-1:0];
   assign we   = ui_in[7];

   // Next read value: hold when disabled, forward write data on a write.
   always_comb begin
      uo_d = uo_q;
      if (ena) begin
         if (we) begin
            uo_d = uio_in;
         end else begin
            uo_d = mem_q[addr];
         end
      end
   end

   // Read register clears on reset; the array is deliberately left untouched
   // and is frozen while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uo_q <= '0;
      end else begin
         uo_q <= uo_d;
         if (ena && we) begin
            mem_q[addr] <= uio_in;
         end
      end
   end

   // uio pins are inputs only.
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;
   assign uo_out  = uo_q;

endmodule

// File: tb/tb_tt_um_urish_dffram.sv
// Directed bench for tt_um_urish_dffram: vector table plus reset/sweep sequences.
module tb_tt_um_urish_dffram;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic [7:0] uo_out;

   int total;
   int bad;

   typedef struct {
      logic       en;
      logic       we;
      logic [6:0] addr;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [13];

   tt_um_urish_dffram dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .uo_out  (uo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one operation, clock it, then sample 1 time unit after the edge.
   task automatic apply(input logic en, input logic w, input logic [6:0] a, input logic [7:0] d);
      ena    = en;
      ui_in  = {w, a};
      uio_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      //           en    we    addr    din    exp
      vecs[0]  = '{1'b1, 1'b1, 7'h00, 8'hA5, 8'hA5};
      vecs[1]  = '{1'b1, 1'b1, 7'h7F, 8'h3C, 8'h3C};
      vecs[2]  = '{1'b1, 1'b0, 7'h00, 8'h00, 8'hA5};
      vecs[3]  = '{1'b1, 1'b0, 7'h7F, 8'h00, 8'h3C};
      vecs[4]  = '{1'b1, 1'b1, 7'h10, 8'hC3, 8'hC3};
      vecs[5]  = '{1'b1, 1'b0, 7'h7F, 8'h00, 8'h3C};
      vecs[6]  = '{1'b1, 1'b0, 7'h10, 8'h00, 8'hC3};
      vecs[7]  = '{1'b0, 1'b1, 7'h00, 8'hFF, 8'hC3};
      vecs[8]  = '{1'b0, 1'b1, 7'h00, 8'hFF, 8'hC3};
      vecs[9]  = '{1'b0, 1'b0, 7'h7F, 8'h00, 8'hC3};
      vecs[10] = '{1'b1, 1'b0, 7'h00, 8'h00, 8'hA5};
      vecs[11] = '{1'b1, 1'b1, 7'h22, 8'h5A, 8'h5A};
      vecs[12] = '{1'b1, 1'b0, 7'h00, 8'h00, 8'hA5};

      // Power-up reset, including clock edges while held.
      #12;
      check("reset_uo", uo_out, 8'h00);
      check("reset_oe", uio_oe, 8'h00);
      check("reset_uio_out", uio_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) begin
         apply(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].din);
         check($sformatf("vec%0d", i), uo_out, vecs[i].exp);
      end

      // Asynchronous reset mid-cycle with uo_out = A5, plus a write attempt held in reset.
      #2;
      ena    = 1'b1;
      ui_in  = {1'b1, 7'h22};
      uio_in = 8'h99;
      rst_n  = 1'b0;
      #1;
      check("async_reset_uo", uo_out, 8'h00);
      check("async_reset_oe", uio_oe, 8'h00);
      @(posedge clk);
      #1;
      check("reset_hold_uo", uo_out, 8'h00);
      check("reset_hold_uio_out", uio_out, 8'h00);
      ui_in = {1'b0, 7'h22};
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("retain_22", uo_out, 8'h5A);
      apply(1'b1, 1'b0, 7'h00, 8'h00);
      check("retain_00", uo_out, 8'hA5);

      // Full sweep: write i^55 everywhere, then read back every word.
      for (int i = 0; i < 128; i++) begin
         apply(1'b1, 1'b1, 7'(i), 8'(i) ^ 8'h55);
         check($sformatf("sweep_wr%0d", i), uo_out, 8'(i) ^ 8'h55);
      end
      for (int i = 0; i < 128; i++) begin
         apply(1'b1, 1'b0, 7'(i), 8'h00);
         check($sformatf("sweep_rd%0d", i), uo_out, 8'(i) ^ 8'h55);
      end

      // Inputs that glitch between edges must have no effect.
      ena    = 1'b1;
      ui_in  = {1'b1, 7'h05};
      uio_in = 8'hEE;
      #3;
      ui_in  = {1'b0, 7'h05};
      uio_in = 8'h00;
      @(posedge clk);
      #1;
      check("glitch_rd05", uo_out, 8'h50);
      apply(1'b1, 1'b0, 7'h05, 8'h00);
      check("glitch_rd05_again", uo_out, 8'h50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
